// File: rtl/riscv_decode_q.sv
// riscv_decode_q: decode stage for the RV32 core.
// Fetched words are buffered in a small queue. The head word is classified into an
// execution unit and its source operands are read from the local register file, with
// optional same-cycle writeback forwarding. The result is held in a registered
// valid/accept interface until the issue stage takes it. A branch request flushes
// both the queue and the held instruction and is forwarded to fetch.
module riscv_decode_q #(
    parameter int FIFO_DEPTH     = 4,
    parameter int NUM_WB         = 4,
    parameter int BYPASS_EN      = 1,
    parameter int SUPPORT_MULDIV = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 fetch_valid_i,
    input  logic [31:0]          fetch_instr_i,
    input  logic [31:0]          fetch_pc_i,
    output logic                 fetch_accept_o,

    input  logic                 branch_request_i,
    input  logic [31:0]          branch_pc_i,
    output logic                 fetch_branch_o,
    output logic [31:0]          fetch_branch_pc_o,

    input  logic [NUM_WB-1:0]    wb_valid_i,
    input  logic [NUM_WB*5-1:0]  wb_idx_i,
    input  logic [NUM_WB*32-1:0] wb_value_i,

    output logic                 opcode_valid_o,
    input  logic                 opcode_accept_i,
    output logic [3:0]           opcode_unit_o,
    output logic                 opcode_illegal_o,
    output logic [31:0]          opcode_opcode_o,
    output logic [31:0]          opcode_pc_o,
    output logic [4:0]           opcode_rd_idx_o,
    output logic [4:0]           opcode_ra_idx_o,
    output logic [4:0]           opcode_rb_idx_o,
    output logic [31:0]          opcode_ra_operand_o,
    output logic [31:0]          opcode_rb_operand_o
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // One-hot unit select {muldiv, csr, lsu, exec}
    localparam logic [3:0] UNIT_EXEC   = 4'b0001;
    localparam logic [3:0] UNIT_LSU    = 4'b0010;
    localparam logic [3:0] UNIT_CSR    = 4'b0100;
    localparam logic [3:0] UNIT_MULDIV = 4'b1000;

    // Highest-numbered writeback port targeting a nonzero idx; bit 32 flags a hit.
    function automatic logic [32:0] wb_match(
        input logic [4:0]           idx,
        input logic [NUM_WB-1:0]    valid,
        input logic [NUM_WB*5-1:0]  idxs,
        input logic [NUM_WB*32-1:0] values
    );
        logic [32:0] res;
        res = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (valid[k] && (idxs[5*k +: 5] == idx) && (idx != 5'd0)) begin
                res = {1'b1, values[32*k +: 32]};
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Instruction queue
    // ------------------------------------------------------------------
    logic [31:0]   q_instr [FIFO_DEPTH];
    logic [31:0]   q_pc    [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] q_count;

    logic q_full;
    logic q_empty;
    logic push;
    logic load;

    logic [31:0] head_instr;
    logic [31:0] head_pc;
    logic [4:0]  head_rd;
    logic [4:0]  head_ra;
    logic [4:0]  head_rb;

    assign q_full  = (q_count == CNT_FULL);
    assign q_empty = (q_count == '0);

    // Push is independent of reset so the reset net only reaches flops asynchronously;
    // the queue flops are held in reset anyway while rst_i is low.
    assign push = fetch_valid_i & ~q_full & ~branch_request_i;
    assign load = ~q_empty & (~opcode_valid_o | opcode_accept_i) & ~branch_request_i;

    assign fetch_accept_o    = rst_i & ~q_full;
    assign fetch_branch_o    = rst_i & branch_request_i;
    assign fetch_branch_pc_o = rst_i ? branch_pc_i : 32'd0;

    assign head_instr = q_instr[rd_ptr];
    assign head_pc    = q_pc[rd_ptr];
    assign head_rd    = head_instr[11:7];
    assign head_ra    = head_instr[19:15];
    assign head_rb    = head_instr[24:20];

    // Queue storage: written at the tail on every accepted push.
    always_ff @(posedge clk_i) begin
        if (push) begin
            q_instr[wr_ptr] <= fetch_instr_i;
            q_pc[wr_ptr]    <= fetch_pc_i;
        end
    end

    // Queue pointers and occupancy; a flush empties the queue outright.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else if (branch_request_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, load})
                2'b10:   q_count <= q_count + CW'(1);
                2'b01:   q_count <= q_count - CW'(1);
                default: q_count <= q_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Classification of the queue head
    // ------------------------------------------------------------------
    logic [3:0] dec_unit;
    logic       dec_illegal;
    logic [6:0] head_funct7;

    assign head_funct7 = head_instr[31:25];

    // Unknown encodings are routed to the csr unit so they take the trap path.
    always_comb begin
        dec_unit    = UNIT_CSR;
        dec_illegal = 1'b1;
        case (head_instr[6:0])
            OP_LOAD, OP_STORE: begin
                dec_unit    = UNIT_LSU;
                dec_illegal = 1'b0;
            end
            OP_SYSTEM: begin
                dec_unit    = UNIT_CSR;
                dec_illegal = 1'b0;
            end
            OP_REG: begin
                if (head_funct7 == F7_MULDIV) begin
                    if (SUPPORT_MULDIV != 0) begin
                        dec_unit    = UNIT_MULDIV;
                        dec_illegal = 1'b0;
                    end
                end else if ((head_funct7 == F7_BASE) || (head_funct7 == F7_ALT)) begin
                    dec_unit    = UNIT_EXEC;
                    dec_illegal = 1'b0;
                end
            end
            OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH: begin
                dec_unit    = UNIT_EXEC;
                dec_illegal = 1'b0;
            end
            default: begin
                dec_unit    = UNIT_CSR;
                dec_illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [31:0] rf [32];

    // Ports are applied in ascending order so the highest port wins on a shared idx; x0 is skipped.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_WB; k++) begin
                if (wb_valid_i[k] && (wb_idx_i[5*k +: 5] != 5'd0)) begin
                    rf[wb_idx_i[5*k +: 5]] <= wb_value_i[32*k +: 32];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand read for the head and writeback snoop for the held instruction
    // ------------------------------------------------------------------
    logic [31:0] rd_ra_val;
    logic [31:0] rd_rb_val;
    logic [32:0] fwd_ra;
    logic [32:0] fwd_rb;
    logic [32:0] snoop_ra;
    logic [32:0] snoop_rb;

    // Head operand values: register file contents, overridden by a same-cycle writeback.
    always_comb begin
        fwd_ra    = wb_match(head_ra, wb_valid_i, wb_idx_i, wb_value_i);
        fwd_rb    = wb_match(head_rb, wb_valid_i, wb_idx_i, wb_value_i);
        rd_ra_val = (head_ra == 5'd0) ? 32'd0 : rf[head_ra];
        rd_rb_val = (head_rb == 5'd0) ? 32'd0 : rf[head_rb];
        if (BYPASS_EN != 0) begin
            if (fwd_ra[32]) begin
                rd_ra_val = fwd_ra[31:0];
            end
            if (fwd_rb[32]) begin
                rd_rb_val = fwd_rb[31:0];
            end
        end
    end

    // Writebacks that target the held instruction's sources while it waits for issue.
    always_comb begin
        snoop_ra = wb_match(opcode_ra_idx_o, wb_valid_i, wb_idx_i, wb_value_i);
        snoop_rb = wb_match(opcode_rb_idx_o, wb_valid_i, wb_idx_i, wb_value_i);
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    // Load the head when the slot frees up, drop it when taken with nothing behind, else snoop.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            opcode_valid_o      <= 1'b0;
            opcode_unit_o       <= '0;
            opcode_illegal_o    <= 1'b0;
            opcode_opcode_o     <= '0;
            opcode_pc_o         <= '0;
            opcode_rd_idx_o     <= '0;
            opcode_ra_idx_o     <= '0;
            opcode_rb_idx_o     <= '0;
            opcode_ra_operand_o <= '0;
            opcode_rb_operand_o <= '0;
        end else if (branch_request_i) begin
            opcode_valid_o <= 1'b0;
        end else if (load) begin
            opcode_valid_o      <= 1'b1;
            opcode_unit_o       <= dec_unit;
            opcode_illegal_o    <= dec_illegal;
            opcode_opcode_o     <= head_instr;
            opcode_pc_o         <= head_pc;
            opcode_rd_idx_o     <= head_rd;
            opcode_ra_idx_o     <= head_ra;
            opcode_rb_idx_o     <= head_rb;
            opcode_ra_operand_o <= rd_ra_val;
            opcode_rb_operand_o <= rd_rb_val;
        end else if (opcode_valid_o && opcode_accept_i) begin
            opcode_valid_o <= 1'b0;
        end else if (opcode_valid_o) begin
            if (snoop_ra[32]) begin
                opcode_ra_operand_o <= snoop_ra[31:0];
            end
            if (snoop_rb[32]) begin
                opcode_rb_operand_o <= snoop_rb[31:0];
            end
        end
    end

endmodule

// File: tb/tb_riscv_decode_q.sv
// Bench for riscv_decode_q: directed scenarios followed by random traffic, with two
// instances (M extension on and off) checked against a queue-based reference model.
module tb_riscv_decode_q;

    localparam int DEPTH = 4;
    localparam int NWB   = 4;

    logic         clk_i;
    logic         rst_i;
    logic         fetch_valid_i;
    logic [31:0]  fetch_instr_i;
    logic [31:0]  fetch_pc_i;
    logic         branch_request_i;
    logic [31:0]  branch_pc_i;
    logic [3:0]   wb_valid_i;
    logic [19:0]  wb_idx_i;
    logic [127:0] wb_value_i;
    logic         opcode_accept_i;

    logic         acc_a, fbr_a, valid_a, ill_a;
    logic [31:0]  fbr_pc_a, opc_a, pc_a, ra_op_a, rb_op_a;
    logic [3:0]   unit_a;
    logic [4:0]   rd_a, ra_a, rb_a;

    logic         acc_b, fbr_b, valid_b, ill_b;
    logic [31:0]  fbr_pc_b, opc_b, pc_b, ra_op_b, rb_op_b;
    logic [3:0]   unit_b;
    logic [4:0]   rd_b, ra_b, rb_b;

    riscv_decode_q #(.FIFO_DEPTH(DEPTH), .NUM_WB(NWB), .BYPASS_EN(1), .SUPPORT_MULDIV(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .fetch_valid_i(fetch_valid_i), .fetch_instr_i(fetch_instr_i), .fetch_pc_i(fetch_pc_i),
        .fetch_accept_o(acc_a),
        .branch_request_i(branch_request_i), .branch_pc_i(branch_pc_i),
        .fetch_branch_o(fbr_a), .fetch_branch_pc_o(fbr_pc_a),
        .wb_valid_i(wb_valid_i), .wb_idx_i(wb_idx_i), .wb_value_i(wb_value_i),
        .opcode_valid_o(valid_a), .opcode_accept_i(opcode_accept_i),
        .opcode_unit_o(unit_a), .opcode_illegal_o(ill_a), .opcode_opcode_o(opc_a),
        .opcode_pc_o(pc_a), .opcode_rd_idx_o(rd_a), .opcode_ra_idx_o(ra_a), .opcode_rb_idx_o(rb_a),
        .opcode_ra_operand_o(ra_op_a), .opcode_rb_operand_o(rb_op_a)
    );

    riscv_decode_q #(.FIFO_DEPTH(DEPTH), .NUM_WB(NWB), .BYPASS_EN(1), .SUPPORT_MULDIV(0)) dut_nm (
        .clk_i(clk_i), .rst_i(rst_i),
        .fetch_valid_i(fetch_valid_i), .fetch_instr_i(fetch_instr_i), .fetch_pc_i(fetch_pc_i),
        .fetch_accept_o(acc_b),
        .branch_request_i(branch_request_i), .branch_pc_i(branch_pc_i),
        .fetch_branch_o(fbr_b), .fetch_branch_pc_o(fbr_pc_b),
        .wb_valid_i(wb_valid_i), .wb_idx_i(wb_idx_i), .wb_value_i(wb_value_i),
        .opcode_valid_o(valid_b), .opcode_accept_i(opcode_accept_i),
        .opcode_unit_o(unit_b), .opcode_illegal_o(ill_b), .opcode_opcode_o(opc_b),
        .opcode_pc_o(pc_b), .opcode_rd_idx_o(rd_b), .opcode_ra_idx_o(ra_b), .opcode_rb_idx_o(rb_b),
        .opcode_ra_operand_o(ra_op_b), .opcode_rb_operand_o(rb_op_b)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } fw_t;

    fw_t         mq[$];
    bit          hv;
    logic [31:0] h_instr, h_pc, h_ra, h_rb;
    logic [31:0] mrf [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        hv      = 1'b0;
        h_instr = '0;
        h_pc    = '0;
        h_ra    = '0;
        h_rb    = '0;
        for (int i = 0; i < 32; i++) mrf[i] = '0;
    endtask

    // Returns {illegal, unit} for a raw instruction word.
    function automatic logic [4:0] exp_class(input logic [31:0] w, input bit md);
        logic [6:0] op;
        logic [6:0] f7;
        op = w[6:0];
        f7 = w[31:25];
        if (op == 7'h03 || op == 7'h23) return 5'b0_0010;
        if (op == 7'h73) return 5'b0_0100;
        if (op == 7'h33) begin
            if (f7 == 7'h01) return md ? 5'b0_1000 : 5'b1_0100;
            if (f7 == 7'h00 || f7 == 7'h20) return 5'b0_0001;
            return 5'b1_0100;
        end
        if (op == 7'h13 || op == 7'h37 || op == 7'h17 || op == 7'h6F || op == 7'h67 || op == 7'h63)
            return 5'b0_0001;
        return 5'b1_0100;
    endfunction

    // Latest-priority writeback lookup on the current inputs; bit 32 set on a hit.
    function automatic logic [32:0] wb_lookup(input logic [4:0] idx);
        logic [32:0] r;
        r = '0;
        if (idx == 5'd0) return r;
        for (int k = 0; k < NWB; k++)
            if (wb_valid_i[k] && wb_idx_i[5*k +: 5] == idx) r = {1'b1, wb_value_i[32*k +: 32]};
        return r;
    endfunction

    function automatic logic [31:0] read_op(input logic [4:0] idx);
        logic [32:0] h;
        h = wb_lookup(idx);
        if (idx == 5'd0) return 32'd0;
        return h[32] ? h[31:0] : mrf[idx];
    endfunction

    task automatic model_clock();
        bit          do_push, do_load;
        fw_t         f;
        logic [32:0] h;
        if (branch_request_i) begin
            mq.delete();
            hv = 1'b0;
        end else begin
            do_push = fetch_valid_i && (mq.size() < DEPTH);
            do_load = (mq.size() > 0) && (!hv || opcode_accept_i);
            if (do_load) begin
                f       = mq.pop_front();
                h_instr = f.instr;
                h_pc    = f.pc;
                h_ra    = read_op(f.instr[19:15]);
                h_rb    = read_op(f.instr[24:20]);
                hv      = 1'b1;
            end else if (hv && opcode_accept_i) begin
                hv = 1'b0;
            end else if (hv) begin
                h = wb_lookup(h_instr[19:15]);
                if (h[32]) h_ra = h[31:0];
                h = wb_lookup(h_instr[24:20]);
                if (h[32]) h_rb = h[31:0];
            end
            if (do_push) begin
                f.instr = fetch_instr_i;
                f.pc    = fetch_pc_i;
                mq.push_back(f);
            end
        end
        for (int k = 0; k < NWB; k++)
            if (wb_valid_i[k] && wb_idx_i[5*k +: 5] != 5'd0) mrf[wb_idx_i[5*k +: 5]] = wb_value_i[32*k +: 32];
    endtask

    task automatic check_held();
        logic [4:0] ca, cb;
        chk("valid_a", 32'(valid_a), 32'(hv));
        chk("valid_b", 32'(valid_b), 32'(hv));
        if (hv) begin
            ca = exp_class(h_instr, 1'b1);
            cb = exp_class(h_instr, 1'b0);
            chk("unit_a", 32'(unit_a), 32'(ca[3:0]));
            chk("ill_a", 32'(ill_a), 32'(ca[4]));
            chk("unit_b", 32'(unit_b), 32'(cb[3:0]));
            chk("ill_b", 32'(ill_b), 32'(cb[4]));
            chk("opcode", opc_a, h_instr);
            chk("pc", pc_a, h_pc);
            chk("rd", 32'(rd_a), 32'(h_instr[11:7]));
            chk("ra", 32'(ra_a), 32'(h_instr[19:15]));
            chk("rb", 32'(rb_a), 32'(h_instr[24:20]));
            chk("ra_op", ra_op_a, h_ra);
            chk("rb_op", rb_op_a, h_rb);
            chk("ra_op_b", ra_op_b, h_ra);
            chk("rb_op_b", rb_op_b, h_rb);
        end
    endtask

    // One clock: check combinational outputs, advance the model, clock, check registered outputs.
    task automatic step();
        #1;
        chk("accept", 32'(acc_a), 32'(mq.size() < DEPTH));
        chk("accept_b", 32'(acc_b), 32'(mq.size() < DEPTH));
        chk("fbranch", 32'(fbr_a), 32'(branch_request_i));
        chk("fbranch_pc", fbr_pc_a, branch_pc_i);
        model_clock();
        @(posedge clk_i);
        #1;
        check_held();
    endtask

    task automatic push_word(input logic [31:0] w, input logic [31:0] pc);
        fetch_valid_i = 1'b1;
        fetch_instr_i = w;
        fetch_pc_i    = pc;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 11))
            0:  w[6:0] = 7'h03;
            1:  w[6:0] = 7'h23;
            2:  w[6:0] = 7'h73;
            3:  w[6:0] = 7'h33;
            4:  w[6:0] = 7'h13;
            5:  w[6:0] = 7'h37;
            6:  w[6:0] = 7'h17;
            7:  w[6:0] = 7'h6F;
            8:  w[6:0] = 7'h67;
            9:  w[6:0] = 7'h63;
            10: w[6:0] = 7'h33;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h01;
            2: w[31:25] = 7'h20;
            default: ;
        endcase
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    logic [31:0] seen_pc [$];

    initial begin
        rst_i            = 1'b0;
        fetch_valid_i    = 1'b0;
        fetch_instr_i    = '0;
        fetch_pc_i       = '0;
        branch_request_i = 1'b1;
        branch_pc_i      = 32'h1234;
        wb_valid_i       = '0;
        wb_idx_i         = '0;
        wb_value_i       = '0;
        opcode_accept_i  = 1'b1;
        model_reset();

        // Reset state: everything low, including the branch pass-through.
        repeat (3) @(posedge clk_i);
        #2;
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_accept", 32'(acc_a), 32'd0);
        chk("rst_fbranch", 32'(fbr_a), 32'd0);
        chk("rst_fbranch_pc", fbr_pc_a, 32'd0);
        chk("rst_unit", 32'(unit_a), 32'd0);
        chk("rst_pc", pc_a, 32'd0);
        chk("rst_ra_op", ra_op_a, 32'd0);
        branch_request_i = 1'b0;
        branch_pc_i      = '0;
        @(negedge clk_i);
        rst_i = 1'b1;

        // addi x1,x0,5: valid two edges after presentation.
        push_word(32'h00500093, 32'h100);
        step();
        chk("t1_not_yet", 32'(valid_a), 32'd0);
        fetch_valid_i = 1'b0;
        step();
        chk("t1_valid", 32'(valid_a), 32'd1);
        chk("t1_unit", 32'(unit_a), 32'b0001);
        chk("t1_pc", pc_a, 32'h100);
        chk("t1_rd", 32'(rd_a), 32'd1);
        chk("t1_ra_op", ra_op_a, 32'd0);
        step();

        // Stall and overfill: 4 queued + 1 held, then drain in order.
        opcode_accept_i = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            push_word({12'(i), 5'd0, 3'd0, 5'(i + 1), 7'h13}, 32'h200 + 32'(4 * i));
            step();
        end
        #1;
        chk("t2_full_accept", 32'(acc_a), 32'd0);
        fetch_valid_i   = 1'b0;
        opcode_accept_i = 1'b1;
        seen_pc.delete();
        for (int i = 0; i < 8; i++) begin
            if (valid_a) seen_pc.push_back(pc_a);
            step();
        end
        chk("t2_count", 32'(seen_pc.size()), 32'd5);
        for (int i = 0; i < seen_pc.size() && i < 5; i++)
            chk("t2_order", seen_pc[i], 32'h200 + 32'(4 * i));

        // Port 0 and port 3 write x5 while add x7,x5,x5 loads.
        push_word(32'h005283B3, 32'h300);
        step();
        fetch_valid_i = 1'b0;
        wb_valid_i    = 4'b1001;
        wb_idx_i      = {5'd5, 5'd0, 5'd0, 5'd5};
        wb_value_i    = {32'h33, 32'h0, 32'h0, 32'h11};
        step();
        chk("t3_ra_op", ra_op_a, 32'h33);
        chk("t3_rb_op", rb_op_a, 32'h33);
        wb_valid_i = '0;
        push_word(32'h00028433, 32'h304);
        step();
        fetch_valid_i = 1'b0;
        step();
        chk("t3_rf5", ra_op_a, 32'h33);

        // mul with and without the M extension; all-ones word.
        push_word(32'h02A302B3, 32'h400);
        step();
        fetch_valid_i = 1'b0;
        step();
        chk("t4_unit_md", 32'(unit_a), 32'b1000);
        chk("t4_ill_md", 32'(ill_a), 32'd0);
        chk("t4_unit_nomd", 32'(unit_b), 32'b0100);
        chk("t4_ill_nomd", 32'(ill_b), 32'd1);
        push_word(32'hFFFFFFFF, 32'h404);
        step();
        fetch_valid_i = 1'b0;
        step();
        chk("t4_ill_ones", 32'(ill_a), 32'd1);
        chk("t4_unit_ones", 32'(unit_a), 32'b0100);

        // Flush with a concurrent fetch word.
        step();
        opcode_accept_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_word(32'h00000013, 32'h500 + 32'(4 * i));
            step();
        end
        branch_request_i = 1'b1;
        branch_pc_i      = 32'h2000;
        push_word(32'h00000013, 32'h600);
        #1;
        chk("t5_fbranch", 32'(fbr_a), 32'd1);
        chk("t5_fbranch_pc", fbr_pc_a, 32'h2000);
        step();
        chk("t5_flushed", 32'(valid_a), 32'd0);
        branch_request_i = 1'b0;
        branch_pc_i      = '0;
        fetch_valid_i    = 1'b0;
        opcode_accept_i  = 1'b1;
        step();
        chk("t5_empty1", 32'(valid_a), 32'd0);
        step();
        chk("t5_empty2", 32'(valid_a), 32'd0);

        // Held add x10,x9,x0 snoops a late writeback to x9; x0 writes are ignored.
        opcode_accept_i = 1'b0;
        push_word(32'h00048533, 32'h700);
        step();
        fetch_valid_i = 1'b0;
        step();
        wb_valid_i = 4'b0010;
        wb_idx_i   = {5'd0, 5'd0, 5'd9, 5'd0};
        wb_value_i = {32'h0, 32'h0, 32'hDEAD, 32'h0};
        step();
        chk("t6_snoop", ra_op_a, 32'hDEAD);
        wb_valid_i = 4'b0001;
        wb_idx_i   = '0;
        wb_value_i = {32'h0, 32'h0, 32'h0, 32'hBEEF};
        step();
        chk("t6_x0_rb", rb_op_a, 32'd0);
        chk("t6_x0_ra", ra_op_a, 32'hDEAD);
        wb_valid_i = '0;

        // Mid-operation reset clears immediately.
        #2;
        rst_i = 1'b0;
        #1;
        chk("t7_valid", 32'(valid_a), 32'd0);
        chk("t7_accept", 32'(acc_a), 32'd0);
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b1;

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            fetch_valid_i    = ($urandom_range(0, 9) < 7);
            fetch_instr_i    = rand_instr();
            fetch_pc_i       = $urandom & 32'hFFFF_FFFC;
            branch_request_i = ($urandom_range(0, 19) == 0);
            branch_pc_i      = $urandom;
            opcode_accept_i  = ($urandom_range(0, 9) < 6);
            wb_valid_i       = 4'($urandom);
            for (int k = 0; k < NWB; k++) begin
                wb_idx_i[5*k +: 5]    = 5'($urandom_range(0, 7));
                wb_value_i[32*k +: 32] = $urandom;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
